// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller:
// FSM state encoding and legal operand-width limits.
package serial_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned WIDTH_MIN = 1;
  localparam int unsigned WIDTH_MAX = 64;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell shared by the serial adder controller.
module full_adder (
  input  logic augend,
  input  logic addend,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);

  assign sum       = augend ^ addend ^ carry_in;
  assign carry_out = (augend & addend) | (carry_in & (augend ^ addend));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared full_adder cell adds two WIDTH-bit operands LSB first,
// one bit per clock, between valid/ready operand and result interfaces.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] augend,
  input  logic [WIDTH-1:0] addend,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
);

  // A 1-bit counter is still needed when WIDTH is 1 ($clog2(1) is 0).
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              carry_q, carry_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              fa_sum;
  logic              fa_carry;

  full_adder u_full_adder (
    .augend    (a_q[0]),
    .addend    (b_q[0]),
    .carry_in  (carry_q),
    .sum       (fa_sum),
    .carry_out (fa_carry)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = augend;
          b_d     = addend;
          carry_d = carry_in;
          sum_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // New sum bit enters at the MSB so the LSB-first stream lands in place.
        a_d               = a_q >> 1;
        b_d               = b_q >> 1;
        sum_d             = sum_q >> 1;
        sum_d[WIDTH-1]    = fa_sum;
        carry_d           = fa_carry;
        cnt_d             = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign sum       = sum_q;
  assign carry_out = carry_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at WIDTH 8, 1 and 13 against plain integer addition.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic        iv8, ir8, ci8, ov8, or8, co8, bz8;
  logic [7:0]  a8, b8, s8;
  logic        iv1, ir1, ci1, ov1, or1, co1, bz1;
  logic [0:0]  a1, b1, s1;
  logic        iv13, ir13, ci13, ov13, or13, co13, bz13;
  logic [12:0] a13, b13, s13;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .augend(a8), .addend(b8),
    .carry_in(ci8), .out_valid(ov8), .out_ready(or8), .sum(s8), .carry_out(co8), .busy(bz8)
  );

  serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .augend(a1), .addend(b1),
    .carry_in(ci1), .out_valid(ov1), .out_ready(or1), .sum(s1), .carry_out(co1), .busy(bz1)
  );

  serial_adder_ctrl #(.WIDTH(13)) u_dut13 (
    .clk(clk), .rst(rst), .in_valid(iv13), .in_ready(ir13), .augend(a13), .addend(b13),
    .carry_in(ci13), .out_valid(ov13), .out_ready(or13), .sum(s13), .carry_out(co13),
    .busy(bz13)
  );

  // One complete WIDTH=8 operation with optional result backpressure.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                      input int hold, input string name);
    logic [8:0] exp;
    int k;
    exp = 9'(a) + 9'(b) + 9'(ci);
    @(negedge clk);
    checks++;
    if (ir8 !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before_accept: got %b want 1", name, ir8);
    end
    iv8 = 1'b1; a8 = a; b8 = b; ci8 = ci;
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
    k = 0;
    while (ov8 !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k != 8) begin
      errors++;
      $display("FAIL %s latency: got %0d want 8", name, k);
    end
    checks++;
    if ({co8, s8} !== exp) begin
      errors++;
      $display("FAIL %s result: got %h want %h", name, {co8, s8}, exp);
    end
    repeat (hold) begin
      or8 = 1'b0;
      @(negedge clk);
      checks++;
      if (ov8 !== 1'b1 || ir8 !== 1'b0 || {co8, s8} !== exp) begin
        errors++;
        $display("FAIL %s stall: got ov=%b ir=%b res=%h want ov=1 ir=0 res=%h",
                 name, ov8, ir8, {co8, s8}, exp);
      end
    end
    or8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    or8 = 1'b0;
    checks++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0 || bz8 !== 1'b0 || {co8, s8} !== exp) begin
      errors++;
      $display("FAIL %s release: got ir=%b ov=%b busy=%b res=%h want ir=1 ov=0 busy=0 res=%h",
               name, ir8, ov8, bz8, {co8, s8}, exp);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0 || bz8 !== 1'b0 || s8 !== 8'h00 || co8 !== 1'b0) begin
      errors++;
      $display("FAIL reset8: got ir=%b ov=%b busy=%b sum=%h co=%b want 1 0 0 00 0",
               ir8, ov8, bz8, s8, co8);
    end
    checks++;
    if (ir13 !== 1'b1 || ov13 !== 1'b0 || s13 !== 13'h0 || co13 !== 1'b0
        || ir1 !== 1'b1 || ov1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_other: got ir13=%b ov13=%b s13=%h co13=%b ir1=%b ov1=%b",
               ir13, ov13, s13, co13, ir1, ov1);
    end
  endtask

  task automatic test_basic();
    run8(8'h5A, 8'h3C, 1'b0, 0, "add_5a_3c");
    run8(8'hFF, 8'h01, 1'b0, 0, "add_ff_01");
    run8(8'hFF, 8'hFF, 1'b1, 0, "add_ff_ff_c");
    repeat (4) run8(8'($urandom), 8'($urandom), 1'($urandom), 0, "rand8");
  endtask

  task automatic test_backpressure();
    run8(8'hC3, 8'h7E, 1'b1, 5, "backpressure");
  endtask

  task automatic test_toggle_inputs();
    logic [8:0] exp;
    int k;
    exp = 9'(8'hA7) + 9'(8'h6B) + 9'(1'b1);
    @(negedge clk);
    iv8 = 1'b1; a8 = 8'hA7; b8 = 8'h6B; ci8 = 1'b1;
    @(posedge clk);
    k = 0;
    @(negedge clk);
    while (ov8 !== 1'b1 && k < 100) begin
      checks++;
      if (ir8 !== 1'b0 || bz8 !== 1'b1) begin
        errors++;
        $display("FAIL toggle_run_flags: got ir=%b busy=%b want 0 1", ir8, bz8);
      end
      a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom); iv8 = 1'($urandom);
      @(negedge clk);
      k++;
    end
    iv8 = 1'b0;
    checks++;
    if (k != 8 || {co8, s8} !== exp) begin
      errors++;
      $display("FAIL toggle_result: got lat=%0d res=%h want lat=8 res=%h", k, {co8, s8}, exp);
    end
    or8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    or8 = 1'b0;
    @(negedge clk);
    checks++;
    if (ir8 !== 1'b1 || bz8 !== 1'b0) begin
      errors++;
      $display("FAIL toggle_no_second_accept: got ir=%b busy=%b want 1 0", ir8, bz8);
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    iv8 = 1'b1; a8 = 8'hE9; b8 = 8'h5D; ci8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0 || bz8 !== 1'b0 || s8 !== 8'h00 || co8 !== 1'b0) begin
      errors++;
      $display("FAIL mid_run_reset: got ir=%b ov=%b busy=%b sum=%h co=%b want 1 0 0 00 0",
               ir8, ov8, bz8, s8, co8);
    end
    run8(8'h12, 8'h34, 1'b0, 0, "post_reset");
  endtask

  task automatic test_width1();
    logic [1:0] exp;
    int k;
    for (int v = 7; v >= 0; v--) begin
      exp = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
      @(negedge clk);
      iv1 = 1'b1; a1 = v[2]; b1 = v[1]; ci1 = v[0];
      @(posedge clk);
      @(negedge clk);
      iv1 = 1'b0;
      k = 0;
      while (ov1 !== 1'b1 && k < 20) begin
        @(negedge clk);
        k++;
      end
      checks++;
      if (k != 1 || {co1, s1} !== exp) begin
        errors++;
        $display("FAIL width1 v=%0d: got lat=%0d res=%b want lat=1 res=%b", v, k, {co1, s1}, exp);
      end
      or1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      or1 = 1'b0;
    end
  endtask

  task automatic test_random13();
    logic [12:0] a, b;
    logic        ci;
    logic [13:0] exp;
    int k;
    for (int n = 0; n < 1000; n++) begin
      a = 13'($urandom); b = 13'($urandom); ci = 1'($urandom);
      exp = 14'(a) + 14'(b) + 14'(ci);
      @(negedge clk);
      iv13 = 1'b1; a13 = a; b13 = b; ci13 = ci;
      @(posedge clk);
      @(negedge clk);
      iv13 = 1'b0; a13 = 13'($urandom); b13 = 13'($urandom);
      k = 0;
      while (ov13 !== 1'b1 && k < 100) begin
        if (ir13 !== 1'b0) k = 1000;
        @(negedge clk);
        k++;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      checks++;
      if (k != 13 || {co13, s13} !== exp) begin
        errors++;
        $display("FAIL random13 #%0d: got lat=%0d res=%h want lat=13 res=%h",
                 n, k, {co13, s13}, exp);
      end
      or13 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      or13 = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    iv8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0; or8 = 1'b0;
    iv1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0; or1 = 1'b0;
    iv13 = 1'b0; a13 = '0; b13 = '0; ci13 = 1'b0; or13 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_toggle_inputs();
    test_reset_mid_run();
    test_width1();
    test_random13();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial addition controller that time-shares one `full_adder` cell to add two WIDTH-bit operands, one bit per clock. It sits between a valid/ready operand source and a valid/ready result sink. It captures operands, sequences LSB-to-MSB through the shared cell while keeping the carry in a register, and presents the assembled sum and carry-out. It trades WIDTH cycles of latency for a single-cell datapath.

## Interface

Parameters:
- `WIDTH`, default 8: operand and sum width in bits; legal range 1 to 64.

Ports:
- `clk`  input  1  sole clock; all state updates on its rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  operand source has a valid operation.
- `in_ready`  output  1  controller can accept an operation; high only in IDLE.
- `augend`  input  WIDTH  first operand; sampled on accept.
- `addend`  input  WIDTH  second operand; sampled on accept.
- `carry_in`  input  1  initial carry; sampled on accept.
- `out_valid`  output  1  `sum` and `carry_out` are valid; high only in DONE.
- `out_ready`  input  1  result sink accepts the result.
- `sum`  output  WIDTH  registered result.
- `carry_out`  output  1  registered final carry.
- `busy`  output  1  high in RUN or DONE.

## Operation

- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid & in_ready` (accept): load `augend` and `addend` into operand shift registers, load `carry_in` into the carry register, clear `sum`, set bit counter to 0, go to RUN.
- **RUN**
  - The `full_adder` is fed operand shift-register bit 0 of each operand and the carry register.
  - Each cycle: store the cell's sum bit into `sum`, shifting right with the new bit entering at bit WIDTH-1; replace the carry register with the cell's carry_out; shift both operand registers right by one; increment the counter.
  - When the counter equals WIDTH-1 at the clock edge, go to DONE.
- **DONE**
  - `out_valid`=1; `sum` holds the full result; `carry_out` = carry register.
  - On `out_valid & out_ready`, go to IDLE.
- Arithmetic: {`carry_out`,`sum`} = `augend` + `addend` + `carry_in`, computed modulo 2^(WIDTH+1), no truncation.
- `in_valid` outside IDLE is ignored, with no side effect.
- Operand inputs may change freely after accept; results depend only on the values captured at accept.
- `sum` and `carry_out` hold their values after leaving DONE until the next accept.
- Bit counter width: $clog2(WIDTH), minimum 1 bit.
- WIDTH=1: RUN lasts exactly one cycle.

## Timing

- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `sum`=0, `carry_out`=0; carry register, counter and operand registers all 0.
- Accept at edge E0. RUN spans the cycles after E0 through E(WIDTH). `out_valid` rises in the cycle after edge E(WIDTH), i.e. WIDTH cycles after accept.
- `out_valid` stays high, and `sum`/`carry_out` stay stable, until the edge where `out_ready`=1. `in_ready` rises in the following cycle.
- There is no overlap between operations: back-to-back throughput is one operation per WIDTH+2 cycles with `out_ready` and `in_valid` held high.
- `in_ready` and `out_valid` are never high in the same cycle.
- All outputs are registered or decoded from state only; there is no combinational path from any input to any output.
- `rst` asserted in any state, including mid-RUN: at that edge, all registers return to reset values and the operation in flight is discarded. `in_ready`=1 in the first cycle after reset.
- `rst` takes priority over an accept or result handshake at the same edge.

## Structure

- Shared package/header holds:
  - the state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - the WIDTH range limits.
- Sub-module: one instance of the existing `full_adder` cell (ports augend, addend, carry_in, sum, carry_out) as the only arithmetic.
- The controller itself contains only the FSM, counter, shift registers and carry register. Do not instantiate a second adder and do not use `+` in the datapath.

## Test plan

- WIDTH=8, accept 0x5A + 0x3C, `carry_in`=0 -> `out_valid` exactly 8 cycles after accept, `sum`=0x96, `carry_out`=0.
- WIDTH=8, 0xFF + 0x01, `carry_in`=0 -> `sum`=0x00, `carry_out`=1; then 0xFF + 0xFF, `carry_in`=1 -> `sum`=0xFF, `carry_out`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE -> `sum`, `carry_out` and `out_valid` stable and `in_ready`=0 throughout; `in_ready`=1 one cycle after the `out_ready` handshake.
- During RUN, toggle `augend`/`addend` each cycle and pulse `in_valid` -> result matches the values captured at accept; no second accept occurs.
- Assert `rst` after bit 3 of an operation -> next cycle `in_ready`=1, `out_valid`=0, `sum`=0, `carry_out`=0; the following operation 0x12 + 0x34 returns 0x46, `carry_out`=0.
- WIDTH=1: 1 + 1, `carry_in`=1 -> `out_valid` 1 cycle after accept, `sum`=1, `carry_out`=1; random regression over 1000 operations at WIDTH=13 compared against a reference `+`.
